data_ram: RTL
=============

DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, giving RAM depth in 32-bit words (power of two, at least 2).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, giving extra access cycles (0..15).
REQ-003 SHALL have port clk_i, input, 1, the single clock, rising edge.
REQ-004 SHALL have port n_rst_i, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port mem_ce_i, input, 1, request valid from the LSU.
REQ-006 SHALL have port mem_we_i, input, 1, 1=store and 0=load.
REQ-007 SHALL have port mem_addr_i, input, 32, byte address.
REQ-008 SHALL have port mem_sel_i, input, 4, byte-lane enables; bit i selects data[8i+7:8i].
REQ-009 SHALL have port mem_data_i, input, 32, store data, already lane-replicated by the LSU.
REQ-010 SHALL have port mem_data_o, output, 32, full read word.
REQ-011 SHALL have port mem_ready_o, output, 1, one-cycle completion strobe.
REQ-012 SHALL have port mem_err_o, output, 1, access error, valid with mem_ready_o.
REQ-013 SHALL have port stall_req_o, output, 1, pipeline hold request to ctrl.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-015 SHALL, in IDLE with mem_ce_i=1, register addr, we, sel and wdata at the clock edge, then go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES=0.
REQ-016 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-017 SHALL commit the access on the edge entering RESP: a store writes only lanes with sel=1; a load registers the word into mem_data_o.
REQ-018 SHALL use word index = mem_addr_i[log2(DEPTH_WORDS)+1:2] and ignore mem_addr_i[1:0]; alignment belongs to the LSU.
REQ-019 SHALL, in RESP, drive mem_ready_o=1 for exactly one cycle, then go to IDLE unconditionally.
REQ-020 SHALL assert mem_ready_o exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 SHALL drive stall_req_o = mem_ce_i AND (state != RESP), combinationally.
REQ-022 SHALL ignore mem_ce_i in WAIT and RESP; no new request is accepted in the RESP cycle, and back-to-back requests are accepted in the following IDLE cycle.
REQ-023 SHALL leave mem_data_o unchanged on stores and hold it until the next load completes.
REQ-024 SHALL treat a store with sel=0000 as completing normally with no array change.
REQ-025 SHALL return the newly written value when a load follows a store to the same word.

Reset
REQ-026 SHALL, on n_rst_i=0, force state=IDLE, counter=0, mem_data_o=0, mem_ready_o=0 and mem_err_o=0 asynchronously; stall_req_o follows REQ-021.
REQ-027 SHALL NOT reset the array contents.
REQ-028 SHALL, on reset in WAIT, abort the access with no array write; a write already committed on the RESP edge is kept.

Configuration
REQ-029 SHALL, with macro DATA_RAM_BOUND_CHECK_EN defined, flag addresses >= DEPTH_WORDS*4: suppress any write, load mem_data_o=0, and assert mem_err_o=1 in the RESP cycle.
REQ-030 SHALL, without DATA_RAM_BOUND_CHECK_EN, tie mem_err_o to 0 and wrap addresses modulo DEPTH_WORDS*4.

Structure
REQ-031 SHALL take the FSM state encoding, the byte-lane width (8) and the lane count (4) from the shared defines package.
REQ-032 SHALL place storage in one sub-module, data_ram_array: synchronous, per-byte-lane write enables, registered read.

Verification
REQ-033 SHALL test, with WAIT_CYCLES=1: store addr 0x10, sel 1111, data 0xDEADBEEF, then load 0x10 -> mem_ready_o 2 cycles after each accept, and the load returns 0xDEADBEEF.
REQ-034 SHALL test a byte store: sel 0010, data 0x55555555 to word 0x10 holding 0xDEADBEEF, then load -> 0xDEAD55EF.
REQ-035 SHALL test WAIT_CYCLES=0 with back-to-back loads and mem_ce_i held high -> ready every other cycle, and stall_req_o low only in RESP cycles.
REQ-036 SHALL test reset asserted in WAIT of a store 0x12345678 to 0x20 -> no write, so a later load of 0x20 returns its prior value, and all outputs read 0 during reset.
REQ-037 SHALL test, with DATA_RAM_BOUND_CHECK_EN and DEPTH_WORDS=16: store to 0x40 -> mem_err_o=1 with ready and no write; without the macro, a load of 0x40 returns word 0.

Source files
------------

// File: rtl/data_ram_pkg.sv
// rtl/data_ram_pkg.sv - shared defines for the data RAM: FSM encoding and byte-lane geometry
//
// Purpose: single source for the access FSM state encoding and the byte-lane
//          layout used by data_ram and data_ram_array.
// Contents: state_t (ST_IDLE, ST_WAIT, ST_RESP), LANE_W, NUM_LANES, WORD_W.
package data_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int LANE_W    = 8;
  localparam int NUM_LANES = 4;
  localparam int WORD_W    = LANE_W * NUM_LANES;

endpackage

// File: rtl/data_ram_array.sv
// rtl/data_ram_array.sv - word storage with per-byte-lane writes and a registered read port
//
// Purpose: DEPTH_WORDS x 32-bit synchronous storage. The array itself has no
//          reset; only the read register is cleared by n_rst_i.
// Ports:
//   clk_i     in   clock, rising edge
//   n_rst_i   in   asynchronous active-low reset (read register only)
//   we_i      in   write strobe
//   be_i      in   byte-lane write enables, bit i -> wdata_i[8i+7:8i]
//   re_i      in   read strobe; updates rdata_o on the next edge
//   rd_clr_i  in   with re_i, load zero instead of the array word
//   addr_i    in   word index
//   wdata_i   in   write data
//   rdata_o   out  registered read data, held until the next read
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 we_i,
  input  logic [NUM_LANES-1:0] be_i,
  input  logic                 re_i,
  input  logic                 rd_clr_i,
  input  logic [AW-1:0]        addr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  output logic [WORD_W-1:0]    rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_q;
  logic [WORD_W-1:0] rdata_d;

  // Contents survive reset, so this process has no reset branch.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be_i[l]) begin
          mem_q[addr_i][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
        end
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = rd_clr_i ? '0 : mem_q[addr_i];
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// rtl/data_ram.sv - LSU-facing data RAM with fixed-latency access FSM
//
// Purpose: accepts one load/store from the LSU in IDLE, waits WAIT_CYCLES
//          cycles, commits on the edge entering RESP and strobes mem_ready_o
//          for one cycle. Optional macro DATA_RAM_BOUND_CHECK_EN flags
//          addresses >= DEPTH_WORDS*4 as errors; without it addresses wrap.
// Ports:
//   clk_i        in   clock, rising edge
//   n_rst_i      in   asynchronous active-low reset
//   mem_ce_i     in   request valid
//   mem_we_i     in   1=store, 0=load
//   mem_addr_i   in   byte address (bits [1:0] ignored)
//   mem_sel_i    in   byte-lane enables
//   mem_data_i   in   store data, lane-replicated
//   mem_data_o   out  load data, held until the next load completes
//   mem_ready_o  out  one-cycle completion strobe
//   mem_err_o    out  access error, valid with mem_ready_o
//   stall_req_o  out  pipeline hold request
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        mem_ready_o,
  output logic        mem_err_o,
  output logic        stall_req_o
);

  localparam int         AW        = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic           we_q, we_d;
  logic [3:0]     sel_q, sel_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           ready_q, ready_d;
  logic           err_q, err_d;

  logic           commit;
  logic           bound_err;
  logic           unused_addr;
  logic [31:0]    acc_addr;
  logic           acc_we;
  logic [3:0]     acc_sel;
  logic [31:0]    acc_wdata;

  // With WAIT_CYCLES=0 the commit edge is also the accept edge, so the
  // request registers are not loaded yet; take the live inputs in IDLE.
  assign acc_addr  = (state_q == ST_IDLE) ? mem_addr_i : addr_q;
  assign acc_we    = (state_q == ST_IDLE) ? mem_we_i   : we_q;
  assign acc_sel   = (state_q == ST_IDLE) ? mem_sel_i  : sel_q;
  assign acc_wdata = (state_q == ST_IDLE) ? mem_data_i : wdata_q;

`ifdef DATA_RAM_BOUND_CHECK_EN
  assign bound_err   = |acc_addr[31:AW+2];
  assign unused_addr = ^acc_addr[1:0];
`else
  // Upper address bits are dropped, so accesses wrap modulo the array size.
  assign bound_err   = 1'b0;
  assign unused_addr = ^{acc_addr[31:AW+2], acc_addr[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_ce_i) begin
          addr_d  = mem_addr_i;
          we_d    = mem_we_i;
          sel_d   = mem_sel_i;
          wdata_d = mem_data_i;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    commit  = (state_d == ST_RESP) && (state_q != ST_RESP);
    ready_d = commit;
    err_d   = commit && bound_err;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  data_ram_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk_i    (clk_i),
    .n_rst_i  (n_rst_i),
    .we_i     (commit && acc_we && !bound_err),
    .be_i     (acc_sel),
    .re_i     (commit && !acc_we),
    .rd_clr_i (bound_err),
    .addr_i   (acc_addr[AW+1:2]),
    .wdata_i  (acc_wdata),
    .rdata_o  (mem_data_o)
  );

  assign mem_ready_o = ready_q;
  assign mem_err_o   = err_q;
  assign stall_req_o = mem_ce_i && (state_q != ST_RESP);

endmodule
